ascon_tag_unit: RTL

//  Sits directly downstream of the 12-round finalization stage; consumes its tag words (y3, y4 after key XOR).

---
 rtl/ascon_tag_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ascon_tag_unit.sv
// Ascon tag unit: serialises the finalization tag (encrypt) or collects and constant-time compares it (decrypt).
// Optional build macro ASCON_TAG_ZEROIZE_EN clears tag/diff on return to IDLE and masks tag_out when not valid.
module ascon_tag_unit #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         fin_valid,
    output logic         fin_ready,
    input  logic         fin_dec,
    input  logic [63:0]  t0,
    input  logic [63:0]  t1,
    output logic [W-1:0] tag_out,
    output logic         tag_out_valid,
    input  logic         tag_out_ready,
    input  logic [W-1:0] tag_in,
    input  logic         tag_in_valid,
    output logic         tag_in_ready,
    output logic         res_valid,
    output logic         res_ok,
    input  logic         res_ready
);
    localparam int BEATS = 128 / W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, EMIT, COLLECT, RESULT} state_t;

    state_t         state_q, state_d;
    logic [127:0]   tag_q, tag_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   diff_q, diff_d;
    logic           fin_ready_q;
    logic           tag_out_valid_q;
    logic           tag_in_ready_q;
    logic           res_valid_q;
    logic           res_ok_q;

    logic [W-1:0]   beat [BEATS];
    logic [W-1:0]   cur_beat;
    logic           last_beat;

    // Beat 0 is the most significant W bits of {t0, t1}.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
            assign beat[gi] = tag_q[127 - gi*W -: W];
        end
    endgenerate

    assign cur_beat  = beat[cnt_q];
    assign last_beat = (cnt_q == CW'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        case (state_q)
            IDLE: begin
                if (fin_valid) begin
                    tag_d   = {t0, t1};
                    cnt_d   = '0;
                    diff_d  = '0;
                    state_d = fin_dec ? COLLECT : EMIT;
                end
            end
            EMIT: begin
                if (tag_out_ready) begin
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = IDLE;
`ifdef ASCON_TAG_ZEROIZE_EN
                        tag_d   = '0;
                        diff_d  = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            COLLECT: begin
                // Every beat is folded in; a mismatch never shortens the collection.
                if (tag_in_valid) begin
                    diff_d = diff_q | (tag_in ^ cur_beat);
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = RESULT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_d = IDLE;
`ifdef ASCON_TAG_ZEROIZE_EN
                    tag_d   = '0;
                    diff_d  = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            tag_q           <= '0;
            cnt_q           <= '0;
            diff_q          <= '0;
            fin_ready_q     <= 1'b1;
            tag_out_valid_q <= 1'b0;
            tag_in_ready_q  <= 1'b0;
            res_valid_q     <= 1'b0;
            res_ok_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            tag_q           <= tag_d;
            cnt_q           <= cnt_d;
            diff_q          <= diff_d;
            fin_ready_q     <= (state_d == IDLE);
            tag_out_valid_q <= (state_d == EMIT);
            tag_in_ready_q  <= (state_d == COLLECT);
            res_valid_q     <= (state_d == RESULT);
            // Only the complete diff is ever exposed; partial compares stay internal.
            res_ok_q        <= (state_d == RESULT) && (diff_d == '0);
        end
    end

    assign fin_ready     = fin_ready_q;
    assign tag_out_valid = tag_out_valid_q;
    assign tag_in_ready  = tag_in_ready_q;
    assign res_valid     = res_valid_q;
    assign res_ok        = res_ok_q;

`ifdef ASCON_TAG_ZEROIZE_EN
    assign tag_out = tag_out_valid_q ? cur_beat : '0;
`else
    assign tag_out = cur_beat;
`endif

endmodule
